// File: rtl/rom_arbiter_if.sv
// Two read ports plus the synchronous ROM connection of the ROM arbiter.
`timescale 1ns/1ps
interface rom_arbiter_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 8
);
   logic              p0_req_in;
   logic [ADDR_W-1:0] p0_addr_in;
   logic              p0_ack_out;
   logic              p0_valid_out;
   logic [DATA_W-1:0] p0_data_out;

   logic              p1_req_in;
   logic [ADDR_W-1:0] p1_addr_in;
   logic              p1_ack_out;
   logic              p1_valid_out;
   logic [DATA_W-1:0] p1_data_out;

   logic [ADDR_W-1:0] rom_addr_out;
   logic              rom_en_out;
   logic [DATA_W-1:0] rom_data_in;
   logic [7:0]        conflict_cnt_out;

   // Arbiter side
   modport slave (
      input  p0_req_in, p0_addr_in, p1_req_in, p1_addr_in, rom_data_in,
      output p0_ack_out, p0_valid_out, p0_data_out,
      output p1_ack_out, p1_valid_out, p1_data_out,
      output rom_addr_out, rom_en_out, conflict_cnt_out
   );

   // Requester / ROM side
   modport master (
      output p0_req_in, p0_addr_in, p1_req_in, p1_addr_in, rom_data_in,
      input  p0_ack_out, p0_valid_out, p0_data_out,
      input  p1_ack_out, p1_valid_out, p1_data_out,
      input  rom_addr_out, rom_en_out, conflict_cnt_out
   );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM between two read ports.
// One access takes three cycles: grant (IDLE), ROM read (ISSUE), capture (CAPTURE).
`timescale 1ns/1ps
module rom_arbiter #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 8
) (
   input  logic          clock_in,
   input  logic          reset_in,
   rom_arbiter_if.slave  bus
);
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

   state_t            state_q, state_d;
   logic              last_q, last_d;     // port granted most recently (1 = port 1)
   logic              win_q, win_d;       // port owning the access in flight
   logic              ack0_q, ack0_d, ack1_q, ack1_d;
   logic              valid0_q, valid0_d, valid1_q, valid1_d;
   logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              rom_en_q, rom_en_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              grant;

   // Next-state and registered-output computation
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      win_d      = win_q;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      valid0_d   = 1'b0;
      valid1_d   = 1'b0;
      data0_d    = data0_q;
      data1_d    = data1_q;
      rom_addr_d = rom_addr_q;
      rom_en_d   = 1'b0;
      cnt_d      = cnt_q;
      grant      = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.p0_req_in && bus.p1_req_in && (cnt_q != CNT_MAX)) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (bus.p0_req_in || bus.p1_req_in) begin
               grant      = (bus.p0_req_in && bus.p1_req_in) ? ~last_q : bus.p1_req_in;
               win_d      = grant;
               rom_addr_d = grant ? bus.p1_addr_in : bus.p0_addr_in;
               rom_en_d   = 1'b1;
               ack0_d     = ~grant;
               ack1_d     = grant;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            if (win_q) begin
               data1_d  = bus.rom_data_in;
               valid1_d = 1'b1;
            end else begin
               data0_d  = bus.rom_data_in;
               valid0_d = 1'b1;
            end
            last_d  = win_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset leaves port 0 as the next tie winner
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         win_q      <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         valid0_q   <= 1'b0;
         valid1_q   <= 1'b0;
         data0_q    <= '0;
         data1_q    <= '0;
         rom_addr_q <= '0;
         rom_en_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         win_q      <= win_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         valid0_q   <= valid0_d;
         valid1_q   <= valid1_d;
         data0_q    <= data0_d;
         data1_q    <= data1_d;
         rom_addr_q <= rom_addr_d;
         rom_en_q   <= rom_en_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.p0_ack_out       = ack0_q;
   assign bus.p0_valid_out     = valid0_q;
   assign bus.p0_data_out      = data0_q;
   assign bus.p1_ack_out       = ack1_q;
   assign bus.p1_valid_out     = valid1_q;
   assign bus.p1_data_out      = data1_q;
   assign bus.rom_addr_out     = rom_addr_q;
   assign bus.rom_en_out       = rom_en_q;
   assign bus.conflict_cnt_out = cnt_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: transaction-level reference model feeding a scoreboard.
`timescale 1ns/1ps
module tb_rom_arbiter;
   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DATA_W = 8;

   logic clock_in = 1'b0;
   logic reset_in = 1'b1;

   rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock_in (clock_in),
      .reset_in (reset_in),
      .bus      (bus)
   );

   always #5 clock_in = ~clock_in;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ROM contents and a synchronous ROM: data appears the cycle after the enabled cycle
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   always @(posedge clock_in) begin
      if (bus.rom_en_out) bus.rom_data_in <= mem[bus.rom_addr_out];
   end

   // ---------------- reference model ----------------
   typedef struct {
      int                port;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      longint            cyc;
   } txn_t;

   txn_t   ackq[$];
   txn_t   valq[$];
   longint cyc = 0;
   int     busy = 0;        // cycles left before the arbiter can grant again
   int     last_port = 1;   // so port 0 wins the first tie
   int     cnt_m = 0;
   logic [DATA_W-1:0] exp_d0 = '0, exp_d1 = '0;

   always @(posedge clock_in or posedge reset_in) begin
      txn_t t;
      int   p;
      if (reset_in) begin
         ackq.delete();
         valq.delete();
         busy      = 0;
         last_port = 1;
         cnt_m     = 0;
         exp_d0    = '0;
         exp_d1    = '0;
      end else begin
         cyc++;
         if (busy > 0) begin
            busy--;
         end else begin
            if (bus.p0_req_in && bus.p1_req_in && cnt_m < 255) cnt_m++;
            if (bus.p0_req_in || bus.p1_req_in) begin
               if (bus.p0_req_in && bus.p1_req_in) p = 1 - last_port;
               else p = bus.p1_req_in ? 1 : 0;
               t.port = p;
               t.addr = (p == 1) ? bus.p1_addr_in : bus.p0_addr_in;
               t.data = mem[t.addr];
               t.cyc  = cyc;
               ackq.push_back(t);
               t.cyc  = cyc + 2;
               valq.push_back(t);
               last_port = p;
               busy = 2;
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clock_in) begin
      txn_t t;
      logic a0, a1, v0, v1, exp_en;
      a0 = bus.p0_ack_out;   a1 = bus.p1_ack_out;
      v0 = bus.p0_valid_out; v1 = bus.p1_valid_out;
      exp_en = (ackq.size() > 0) && (ackq[0].cyc == cyc);

      check("ack_exclusive", longint'(a0 & a1), 0);
      check("valid_exclusive", longint'(v0 & v1), 0);
      check("rom_en", longint'(bus.rom_en_out), longint'(exp_en));

      if (a0 || a1) begin
         if (ackq.size() == 0) check("ack_spurious", longint'(ackq.size()), 1);
         else begin
            t = ackq.pop_front();
            check("ack_port", longint'(a1), t.port);
            check("ack_cycle", cyc, t.cyc);
            check("rom_addr", longint'(bus.rom_addr_out), longint'(t.addr));
         end
      end else if (ackq.size() > 0 && ackq[0].cyc <= cyc) begin
         check("ack_missing", longint'(a0 | a1), 1);
         void'(ackq.pop_front());
      end

      if (v0 || v1) begin
         if (valq.size() == 0) check("valid_spurious", longint'(valq.size()), 1);
         else begin
            t = valq.pop_front();
            check("valid_port", longint'(v1), t.port);
            check("valid_cycle", cyc, t.cyc);
            if (t.port == 1) exp_d1 = t.data;
            else exp_d0 = t.data;
         end
      end else if (valq.size() > 0 && valq[0].cyc <= cyc) begin
         check("valid_missing", longint'(v0 | v1), 1);
         void'(valq.pop_front());
      end

      check("p0_data", longint'(bus.p0_data_out), longint'(exp_d0));
      check("p1_data", longint'(bus.p1_data_out), longint'(exp_d1));
      check("conflict_cnt", longint'(bus.conflict_cnt_out), cnt_m);
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clock_in);
      #1;
   endtask

   // Returns the acknowledged port, or -1 if no ack arrives within the budget
   task automatic wait_ack(output int port);
      port = -1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.p0_ack_out) begin port = 0; break; end
         if (bus.p1_ack_out) begin port = 1; break; end
      end
   endtask

   task automatic do_reset();
      bus.p0_req_in = 1'b0;
      bus.p1_req_in = 1'b0;
      reset_in = 1'b1;
      tick();
      tick();
      reset_in = 1'b0;
   endtask

   initial begin
      int port;
      int seen;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom);
      mem[12'h123] = 8'hA5;
      bus.p0_req_in  = 1'b0;
      bus.p1_req_in  = 1'b0;
      bus.p0_addr_in = '0;
      bus.p1_addr_in = '0;

      // Reset state
      tick(); tick(); tick();
      check("rst_p0_data", longint'(bus.p0_data_out), 0);
      check("rst_p1_data", longint'(bus.p1_data_out), 0);
      check("rst_rom_addr", longint'(bus.rom_addr_out), 0);
      check("rst_cnt", longint'(bus.conflict_cnt_out), 0);
      reset_in = 1'b0;

      // Single read from port 0
      bus.p0_addr_in = 12'h123;
      bus.p0_req_in  = 1'b1;
      wait_ack(port);
      check("single_ack_port", port, 0);
      bus.p0_req_in = 1'b0;
      tick(); tick();
      check("single_valid", longint'(bus.p0_valid_out), 1);
      check("single_data", longint'(bus.p0_data_out), 8'hA5);
      check("single_p1_valid", longint'(bus.p1_valid_out), 0);
      tick(); tick();

      // Tie after reset: grants alternate starting with port 0
      do_reset();
      bus.p0_addr_in = 12'h010;
      bus.p1_addr_in = 12'h020;
      bus.p0_req_in  = 1'b1;
      bus.p1_req_in  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_ack(port);
         check("tie_order", port, i % 2);
      end
      bus.p0_req_in = 1'b0;
      bus.p1_req_in = 1'b0;
      tick(); tick(); tick();

      // Back-to-back on port 1: valid then the next ack on the following cycle
      bus.p1_addr_in = 12'h0AB;
      bus.p1_req_in  = 1'b1;
      wait_ack(port);
      check("b2b_first", port, 1);
      for (int i = 0; i < 4; i++) begin
         bus.p1_addr_in = ADDR_W'($urandom);
         tick(); tick();
         check("b2b_valid", longint'(bus.p1_valid_out), 1);
         tick();
         check("b2b_ack", longint'(bus.p1_ack_out), 1);
      end
      bus.p1_req_in = 1'b0;
      tick(); tick(); tick();

      // Counter saturation under sustained contention
      do_reset();
      bus.p0_req_in = 1'b1;
      bus.p1_req_in = 1'b1;
      for (int i = 0; i < 1000; i++) tick();
      check("sat_cnt", longint'(bus.conflict_cnt_out), 255);
      for (int i = 0; i < 30; i++) tick();
      check("sat_hold", longint'(bus.conflict_cnt_out), 255);

      // Reset during CAPTURE aborts the access
      do_reset();
      bus.p0_addr_in = 12'h321;
      bus.p1_addr_in = 12'h654;
      bus.p0_req_in  = 1'b1;
      bus.p1_req_in  = 1'b1;
      wait_ack(port);
      check("abort_first", port, 0);
      tick();
      reset_in = 1'b1;
      #1;
      check("abort_valid0", longint'(bus.p0_valid_out), 0);
      check("abort_data0", longint'(bus.p0_data_out), 0);
      check("abort_ack1", longint'(bus.p1_ack_out), 0);
      check("abort_rom_en", longint'(bus.rom_en_out), 0);
      check("abort_rom_addr", longint'(bus.rom_addr_out), 0);
      check("abort_cnt", longint'(bus.conflict_cnt_out), 0);
      tick();
      reset_in = 1'b0;
      wait_ack(port);
      check("abort_retie", port, 0);
      bus.p0_req_in = 1'b0;
      bus.p1_req_in = 1'b0;
      tick(); tick(); tick(); tick(); tick();

      // Dropped port-1 request while port 0 reads the top address
      do_reset();
      bus.p0_addr_in = 12'hFFF;
      bus.p0_req_in  = 1'b1;
      wait_ack(port);
      check("drop_p0_ack", port, 0);
      bus.p0_req_in  = 1'b0;
      bus.p1_addr_in = 12'h555;
      bus.p1_req_in  = 1'b1;
      tick();
      bus.p1_req_in  = 1'b0;
      tick();
      check("drop_top_data", longint'(bus.p0_data_out), longint'(mem[12'hFFF]));
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.p1_ack_out || bus.p1_valid_out) seen++;
      end
      check("drop_no_p1", seen, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         tick();
         if (bus.p0_req_in && bus.p0_ack_out) begin
            bus.p0_addr_in = ($urandom_range(0, 7) == 0) ? 12'hFFF : ADDR_W'($urandom);
            bus.p0_req_in  = 1'($urandom_range(0, 1));
         end else if (bus.p0_req_in) begin
            if ($urandom_range(0, 15) == 0) bus.p0_req_in = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            bus.p0_addr_in = ADDR_W'($urandom);
            bus.p0_req_in  = 1'b1;
         end
         if (bus.p1_req_in && bus.p1_ack_out) begin
            bus.p1_addr_in = ($urandom_range(0, 7) == 0) ? 12'h000 : ADDR_W'($urandom);
            bus.p1_req_in  = 1'($urandom_range(0, 1));
         end else if (bus.p1_req_in) begin
            if ($urandom_range(0, 15) == 0) bus.p1_req_in = 1'b0;
         end else if ($urandom_range(0, 2) == 0) begin
            bus.p1_addr_in = ADDR_W'($urandom);
            bus.p1_req_in  = 1'b1;
         end
      end
      bus.p0_req_in = 1'b0;
      bus.p1_req_in = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      check("drain_ackq", longint'(ackq.size()), 0);
      check("drain_valq", longint'(valq.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
